// File: rtl/cache_line_ctrl_if.sv
// Request, line-status and refill-command bundle between the requesters,
// the cache_line instances and the replacement controller.
interface cache_line_ctrl_if #(
  parameter int unsigned ADDRBITS = 32,
  parameter int unsigned LSBBITS  = 7,
  parameter int unsigned LINES    = 4,
  parameter int unsigned TTLBITS  = 8
);
  logic [ADDRBITS-1:0]         dcache_rdaddr;
  logic                        dcache_rdreq;
  logic [ADDRBITS-1:0]         dcache_wraddr;
  logic                        dcache_wrreq;
  logic [ADDRBITS-1:0]         icache_rdaddr;
  logic                        icache_rdreq;
  logic [LINES-1:0]            line_miss;
  logic [LINES-1:0]            line_dirty;
  logic [LINES*TTLBITS-1:0]    line_ttl;
  logic [LINES-1:0]            line_ready;
  logic [LINES-1:0]            line_flush;
  logic [LINES-1:0]            line_fill;
  logic [ADDRBITS-LSBBITS-1:0] cache_new_region;
  logic                        miss_stall;
  logic                        flush_all_req;
  logic                        flush_all_done;
  logic [15:0]                 refill_count;
  logic                        ctrl_error;

  // Requester / cache-line side
  modport master (
    output dcache_rdaddr, dcache_rdreq, dcache_wraddr, dcache_wrreq,
    output icache_rdaddr, icache_rdreq, flush_all_req,
    output line_miss, line_dirty, line_ttl, line_ready,
    input  line_flush, line_fill, cache_new_region, miss_stall,
    input  flush_all_done, refill_count, ctrl_error
  );

  // Controller side
  modport slave (
    input  dcache_rdaddr, dcache_rdreq, dcache_wraddr, dcache_wrreq,
    input  icache_rdaddr, icache_rdreq, flush_all_req,
    input  line_miss, line_dirty, line_ttl, line_ready,
    output line_flush, line_fill, cache_new_region, miss_stall,
    output flush_all_done, refill_count, ctrl_error
  );
endinterface

// File: rtl/cache_line_ctrl.sv
// Replacement/refill controller for the hybrid cache: detects a global miss,
// evicts the lowest-TTL line with a fill (plus flush when dirty), and
// sequences a write-back of every dirty line on a flush-all request.
module cache_line_ctrl #(
  parameter int unsigned ADDRBITS   = 32,
  parameter int unsigned LSBBITS    = 7,
  parameter int unsigned LINES      = 4,
  parameter int unsigned LINEBITS   = 2,
  parameter int unsigned TTLBITS    = 8,
  parameter logic [15:0] REFILL_SAT = 16'hFFFF
) (
  input logic              clk,
  input logic              reset,
  cache_line_ctrl_if.slave bus
);
  localparam int unsigned REGBITS = ADDRBITS - LSBBITS;
  localparam int unsigned IDXBITS = LINEBITS + 1;
  localparam int unsigned CNTBITS = 16;
  localparam int unsigned TMOBITS = 3;

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_ISSUE, S_WAIT_BUSY, S_WAIT_READY, S_FA_NEXT
  } state_t;

  state_t               r_state,      w_state_nxt;
  logic [REGBITS-1:0]   r_region,     w_region_nxt;
  logic [REGBITS-1:0]   r_new_region, w_new_region_nxt;
  logic [LINEBITS-1:0]  r_victim,     w_victim_nxt;
  logic [IDXBITS-1:0]   r_fa_idx,     w_fa_idx_nxt;
  logic                 r_fa_pend,    w_fa_pend_nxt;
  logic                 r_fa_active,  w_fa_active_nxt;
  logic [TMOBITS-1:0]   r_busy_cnt,   w_busy_cnt_nxt;
  logic [LINES-1:0]     r_flush,      w_flush_nxt;
  logic [LINES-1:0]     r_fill,       w_fill_nxt;
  logic                 r_stall,      w_stall_nxt;
  logic                 r_done,       w_done_nxt;
  logic [CNTBITS-1:0]   r_count,      w_count_nxt;
  logic                 r_error,      w_error_nxt;

  logic                 w_req_any;
  logic                 w_global_miss;
  logic [REGBITS-1:0]   w_req_region;
  logic [LINEBITS-1:0]  w_min_idx;
  logic [TTLBITS-1:0]   w_min_ttl;
  logic [LINEBITS-1:0]  w_fa_line;
  logic                 w_vic_ready;
  logic                 w_release;

  assign w_fa_line   = r_fa_idx[LINEBITS-1:0];
  assign w_vic_ready = bus.line_ready[r_victim];

  // Global miss detection and request priority (write > data read > ifetch)
  always_comb begin
    w_req_any     = bus.dcache_wrreq | bus.dcache_rdreq | bus.icache_rdreq;
    w_global_miss = w_req_any & (&bus.line_miss) & (&bus.line_ready);
    if (bus.dcache_wrreq)
      w_req_region = bus.dcache_wraddr[ADDRBITS-1:LSBBITS];
    else if (bus.dcache_rdreq)
      w_req_region = bus.dcache_rdaddr[ADDRBITS-1:LSBBITS];
    else
      w_req_region = bus.icache_rdaddr[ADDRBITS-1:LSBBITS];
  end

  // Minimum-TTL victim search; strict compare keeps the lowest index on ties
  always_comb begin
    w_min_idx = '0;
    w_min_ttl = bus.line_ttl[TTLBITS-1:0];
    for (int i = 1; i < int'(LINES); i++) begin
      if (bus.line_ttl[i*TTLBITS +: TTLBITS] < w_min_ttl) begin
        w_min_ttl = bus.line_ttl[i*TTLBITS +: TTLBITS];
        w_min_idx = LINEBITS'(i);
      end
    end
  end

  // Next-state and registered-output computation
  always_comb begin
    w_state_nxt      = r_state;
    w_region_nxt     = r_region;
    w_new_region_nxt = r_new_region;
    w_victim_nxt     = r_victim;
    w_fa_idx_nxt     = r_fa_idx;
    w_fa_pend_nxt    = r_fa_pend | bus.flush_all_req;
    w_fa_active_nxt  = r_fa_active;
    w_busy_cnt_nxt   = r_busy_cnt;
    w_flush_nxt      = '0;
    w_fill_nxt       = '0;
    w_stall_nxt      = r_stall;
    w_done_nxt       = 1'b0;
    w_count_nxt      = r_count;
    w_error_nxt      = r_error;
    w_release        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_global_miss) begin
          w_region_nxt = w_req_region;
          w_stall_nxt  = 1'b1;
          w_state_nxt  = S_SELECT;
        end else if (r_fa_pend) begin
          w_fa_idx_nxt    = '0;
          w_fa_active_nxt = 1'b1;
          w_stall_nxt     = 1'b1;
          w_state_nxt     = S_FA_NEXT;
        end
      end
      // Pulses are registered here so they are visible during ISSUE
      S_SELECT: begin
        w_victim_nxt           = w_min_idx;
        w_new_region_nxt       = r_region;
        w_fill_nxt[w_min_idx]  = 1'b1;
        w_flush_nxt[w_min_idx] = bus.line_dirty[w_min_idx];
        if (r_count != REFILL_SAT)
          w_count_nxt = r_count + CNTBITS'(1);
        w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        w_busy_cnt_nxt = '0;
        w_state_nxt    = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!w_vic_ready) begin
          w_state_nxt = S_WAIT_READY;
        end else if (r_busy_cnt == TMOBITS'(3)) begin
          w_error_nxt = 1'b1;
          w_release   = 1'b1;
        end else begin
          w_busy_cnt_nxt = r_busy_cnt + TMOBITS'(1);
        end
      end
      S_WAIT_READY: begin
        if (w_vic_ready)
          w_release = 1'b1;
      end
      S_FA_NEXT: begin
        if (r_fa_idx == IDXBITS'(LINES)) begin
          w_done_nxt      = 1'b1;
          w_fa_pend_nxt   = 1'b0;
          w_fa_active_nxt = 1'b0;
          w_stall_nxt     = 1'b0;
          w_state_nxt     = S_IDLE;
        end else if (bus.line_dirty[w_fa_line]) begin
          w_victim_nxt           = w_fa_line;
          w_flush_nxt[w_fa_line] = 1'b1;
          w_state_nxt            = S_ISSUE;
        end else begin
          w_fa_idx_nxt = r_fa_idx + IDXBITS'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Handshake finished (or timed out): resume flush-all or release stall
    if (w_release) begin
      if (r_fa_active) begin
        w_fa_idx_nxt = r_fa_idx + IDXBITS'(1);
        w_state_nxt  = S_FA_NEXT;
      end else begin
        w_stall_nxt = 1'b0;
        w_state_nxt = S_IDLE;
      end
    end
  end

  // State and output registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_region     <= '0;
      r_new_region <= '0;
      r_victim     <= '0;
      r_fa_idx     <= '0;
      r_fa_pend    <= 1'b0;
      r_fa_active  <= 1'b0;
      r_busy_cnt   <= '0;
      r_flush      <= '0;
      r_fill       <= '0;
      r_stall      <= 1'b0;
      r_done       <= 1'b0;
      r_count      <= '0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_region     <= w_region_nxt;
      r_new_region <= w_new_region_nxt;
      r_victim     <= w_victim_nxt;
      r_fa_idx     <= w_fa_idx_nxt;
      r_fa_pend    <= w_fa_pend_nxt;
      r_fa_active  <= w_fa_active_nxt;
      r_busy_cnt   <= w_busy_cnt_nxt;
      r_flush      <= w_flush_nxt;
      r_fill       <= w_fill_nxt;
      r_stall      <= w_stall_nxt;
      r_done       <= w_done_nxt;
      r_count      <= w_count_nxt;
      r_error      <= w_error_nxt;
    end
  end

  assign bus.line_flush       = r_flush;
  assign bus.line_fill        = r_fill;
  assign bus.cache_new_region = r_new_region;
  assign bus.miss_stall       = r_stall;
  assign bus.flush_all_done   = r_done;
  assign bus.refill_count     = r_count;
  assign bus.ctrl_error       = r_error;
endmodule

// File: tb/tb_cache_line_ctrl.sv
// Bench for cache_line_ctrl: a cache-line ready model plus a queue of
// expected flush/fill pulses popped as the controller issues them.
module tb_cache_line_ctrl;
  localparam logic [15:0] SAT = 16'd8;

  typedef struct packed {
    logic [3:0]  flush;
    logic [3:0]  fill;
    logic [24:0] region;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [15:0] exp_count = '0;
  logic [24:0] exp_region = '0;

  // Line model controls and state
  bit   m_stuck = 1'b0;
  int   m_delay = 3;
  int   m_cnt = 0;
  int   m_idx = 0;
  int   m_pulses = 0;

  cache_line_ctrl_if #(.ADDRBITS(32), .LSBBITS(7), .LINES(4), .TTLBITS(8)) bus ();

  cache_line_ctrl #(
    .ADDRBITS(32), .LSBBITS(7), .LINES(4), .LINEBITS(2), .TTLBITS(8), .REFILL_SAT(SAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Cache-line model: drops ready the cycle after a pulse, raises it m_delay cycles later
  always @(posedge clk) begin
    if (reset) begin
      bus.line_ready <= 4'b1111;
      m_cnt <= 0;
    end else begin
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) bus.line_ready[m_idx] <= 1'b1;
      end
      if ((bus.line_flush | bus.line_fill) != 4'b0) begin
        m_pulses <= m_pulses + 1;
        if (!m_stuck) begin
          for (int i = 0; i < 4; i++)
            if (bus.line_flush[i] | bus.line_fill[i]) m_idx <= i;
          bus.line_ready <= bus.line_ready & ~(bus.line_flush | bus.line_fill);
          m_cnt <= m_delay;
        end
      end
    end
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == SAT) ? SAT : c + 16'd1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_req(input logic wr, input logic rd, input logic ic,
                         input logic [31:0] wa, input logic [31:0] ra, input logic [31:0] ia);
    bus.dcache_wrreq  = wr;
    bus.dcache_rdreq  = rd;
    bus.icache_rdreq  = ic;
    bus.dcache_wraddr = wa;
    bus.dcache_rdaddr = ra;
    bus.icache_rdaddr = ia;
  endtask

  task automatic pulse_flush_all();
    bus.flush_all_req = 1'b1;
    tick(1);
    bus.flush_all_req = 1'b0;
  endtask

  task automatic wait_pulse(input int budget, output logic [3:0] fl, output logic [3:0] fi,
                            output logic [24:0] rg, output bit got);
    got = 1'b0; fl = '0; fi = '0; rg = '0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if ((bus.line_flush | bus.line_fill) != 4'b0) begin
        fl = bus.line_flush; fi = bus.line_fill; rg = bus.cache_new_region; got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_stall_low(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!bus.miss_stall) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic [51:0] outs;
    set_req(0, 0, 0, 0, 0, 0);
    bus.flush_all_req = 1'b0;
    bus.line_miss  = 4'b1111;
    bus.line_dirty = 4'b0000;
    bus.line_ttl   = {8'd40, 8'd10, 8'd10, 8'd90};
    reset = 1'b1;
    tick(3);
    outs = {bus.line_flush, bus.line_fill, bus.cache_new_region, bus.miss_stall,
            bus.flush_all_done, bus.refill_count, bus.ctrl_error};
    checks++;
    if (outs !== 52'd0) begin errors++; $display("FAIL reset_outputs: got %h exp 0", outs); end
    reset = 1'b0;
    tick(3);
    checks++;
    if (bus.miss_stall !== 1'b0 || bus.line_fill !== 4'b0) begin
      errors++; $display("FAIL idle_quiet: stall %b fill %b exp 0/0", bus.miss_stall, bus.line_fill);
    end
  endtask

  task automatic test_refill_clean();
    logic [3:0] fl, fi; logic [24:0] rg; bit got, ok; exp_t e;
    m_delay = 3;
    set_req(0, 1, 0, 0, 32'h0000_1234, 0);
    exp_region = 25'h24;
    exp_count = sat_inc(exp_count);
    sb.push_back('{flush: 4'b0000, fill: 4'b0010, region: exp_region});
    wait_pulse(10, fl, fi, rg, got);
    e = sb.pop_front();
    checks++;
    if (!got || {fl, fi, rg} !== e) begin
      errors++; $display("FAIL clean_pulse: got %b/%b/%h exp %b/%b/%h", fl, fi, rg, e.flush, e.fill, e.region);
    end
    checks++;
    if (bus.refill_count !== exp_count || bus.miss_stall !== 1'b1) begin
      errors++; $display("FAIL clean_count: cnt %0d stall %b exp %0d/1", bus.refill_count, bus.miss_stall, exp_count);
    end
    set_req(0, 0, 0, 0, 0, 0);
    tick(1);
    checks++;
    if ((bus.line_fill | bus.line_flush) !== 4'b0) begin
      errors++; $display("FAIL clean_one_cycle: fill %b flush %b exp 0", bus.line_fill, bus.line_flush);
    end
    wait_stall_low(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL clean_release: stall %b exp 0", bus.miss_stall); end
    checks++;
    if (bus.cache_new_region !== exp_region) begin
      errors++; $display("FAIL region_hold: got %h exp %h", bus.cache_new_region, exp_region);
    end
  endtask

  task automatic test_refill_dirty();
    logic [3:0] fl, fi; logic [24:0] rg; bit got; exp_t e;
    int r, s;
    m_delay = 20;
    bus.line_dirty = 4'b0010;
    set_req(0, 1, 0, 0, 32'h0000_1234, 0);
    exp_count = sat_inc(exp_count);
    sb.push_back('{flush: 4'b0010, fill: 4'b0010, region: 25'h24});
    wait_pulse(10, fl, fi, rg, got);
    e = sb.pop_front();
    checks++;
    if (!got || {fl, fi, rg} !== e) begin
      errors++; $display("FAIL dirty_pulse: got %b/%b/%h exp %b/%b/%h", fl, fi, rg, e.flush, e.fill, e.region);
    end
    set_req(0, 0, 0, 0, 0, 0);
    r = -1; s = -1;
    for (int k = 1; k <= 40 && s < 0; k++) begin
      @(negedge clk);
      if (r < 0 && bus.line_ready[1]) r = k;
      if (s < 0 && !bus.miss_stall) s = k;
    end
    checks++;
    if (r != 21) begin errors++; $display("FAIL dirty_ready_rise: cycle %0d exp 21", r); end
    checks++;
    if (s != r + 1) begin errors++; $display("FAIL dirty_stall_fall: cycle %0d exp %0d", s, r + 1); end
    bus.line_dirty = 4'b0000;
  endtask

  task automatic test_priority();
    logic [3:0] fl, fi; logic [24:0] rg; bit got, ok; exp_t e;
    logic [2:0]  t_req [3] = '{3'b101, 3'b011, 3'b111};
    logic [31:0] t_wa  [3] = '{32'h80, 32'h0, 32'h1_0000};
    logic [31:0] t_ra  [3] = '{32'h0, 32'h200, 32'h2_0000};
    logic [31:0] t_ia  [3] = '{32'h100, 32'h300, 32'h3_0000};
    logic [24:0] t_exp [3] = '{25'h1, 25'h4, 25'h200};
    m_delay = 2;
    for (int t = 0; t < 3; t++) begin
      set_req(t_req[t][2], t_req[t][1], t_req[t][0], t_wa[t], t_ra[t], t_ia[t]);
      exp_region = t_exp[t];
      exp_count = sat_inc(exp_count);
      sb.push_back('{flush: 4'b0000, fill: 4'b0010, region: exp_region});
      wait_pulse(10, fl, fi, rg, got);
      e = sb.pop_front();
      checks++;
      if (!got || {fl, fi, rg} !== e) begin
        errors++; $display("FAIL priority_%0d: got %b/%b/%h exp %b/%b/%h", t, fl, fi, rg, e.flush, e.fill, e.region);
      end
      set_req(0, 0, 0, 0, 0, 0);
      wait_stall_low(20, ok);
      checks++;
      if (!ok || bus.refill_count !== exp_count) begin
        errors++; $display("FAIL priority_done_%0d: cnt %0d stall %b exp %0d/0", t, bus.refill_count, bus.miss_stall, exp_count);
      end
    end
  endtask

  task automatic test_no_action();
    int p0;
    p0 = m_pulses;
    bus.line_miss = 4'b1110;
    set_req(0, 1, 1, 0, 32'h1234, 32'h5678);
    tick(8);
    checks++;
    if (bus.miss_stall !== 1'b0 || m_pulses != p0) begin
      errors++; $display("FAIL no_miss_action: stall %b pulses %0d exp 0/%0d", bus.miss_stall, m_pulses, p0);
    end
    set_req(0, 0, 0, 0, 0, 0);
    bus.line_miss = 4'b1111;
    tick(1);
  endtask

  task automatic test_flush_all();
    logic [3:0] fl, fi; logic [24:0] rg; bit got; exp_t e;
    int p0, n_done, n_fill;
    m_delay = 3;
    p0 = m_pulses;
    bus.line_dirty = 4'b1010;
    sb.push_back('{flush: 4'b0010, fill: 4'b0000, region: exp_region});
    sb.push_back('{flush: 4'b1000, fill: 4'b0000, region: exp_region});
    pulse_flush_all();
    wait_pulse(10, fl, fi, rg, got);
    e = sb.pop_front();
    checks++;
    if (!got || {fl, fi, rg} !== e || bus.miss_stall !== 1'b1) begin
      errors++; $display("FAIL fa_first: got %b/%b/%h stall %b exp %b/%b/%h stall 1", fl, fi, rg, bus.miss_stall, e.flush, e.fill, e.region);
    end
    pulse_flush_all();
    wait_pulse(30, fl, fi, rg, got);
    e = sb.pop_front();
    checks++;
    if (!got || {fl, fi, rg} !== e || bus.miss_stall !== 1'b1) begin
      errors++; $display("FAIL fa_second: got %b/%b/%h stall %b exp %b/%b/%h stall 1", fl, fi, rg, bus.miss_stall, e.flush, e.fill, e.region);
    end
    checks++;
    if (bus.line_ready[1] !== 1'b1) begin errors++; $display("FAIL fa_order: ready1 %b exp 1", bus.line_ready[1]); end
    n_done = 0; n_fill = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.flush_all_done) n_done++;
      if (bus.line_fill != 4'b0) n_fill++;
    end
    checks++;
    if (n_done != 1 || n_fill != 0) begin
      errors++; $display("FAIL fa_done: done %0d fills %0d exp 1/0", n_done, n_fill);
    end
    checks++;
    if (m_pulses - p0 != 2 || bus.miss_stall !== 1'b0 || bus.refill_count !== exp_count) begin
      errors++; $display("FAIL fa_totals: pulses %0d stall %b cnt %0d exp 2/0/%0d", m_pulses - p0, bus.miss_stall, bus.refill_count, exp_count);
    end
    bus.line_dirty = 4'b0000;
  endtask

  task automatic test_timeout();
    logic [3:0] fl, fi; logic [24:0] rg; bit got, ok; exp_t e;
    int n_done;
    m_stuck = 1'b1;
    set_req(0, 1, 0, 0, 32'h0000_1234, 0);
    exp_region = 25'h24;
    exp_count = sat_inc(exp_count);
    sb.push_back('{flush: 4'b0000, fill: 4'b0010, region: exp_region});
    wait_pulse(10, fl, fi, rg, got);
    e = sb.pop_front();
    checks++;
    if (!got || {fl, fi, rg} !== e) begin
      errors++; $display("FAIL tmo_pulse: got %b/%b/%h exp %b/%b/%h", fl, fi, rg, e.flush, e.fill, e.region);
    end
    set_req(0, 0, 0, 0, 0, 0);
    tick(4);
    checks++;
    if (bus.ctrl_error !== 1'b0 || bus.miss_stall !== 1'b1) begin
      errors++; $display("FAIL tmo_early: err %b stall %b exp 0/1", bus.ctrl_error, bus.miss_stall);
    end
    tick(1);
    checks++;
    if (bus.ctrl_error !== 1'b1 || bus.miss_stall !== 1'b0) begin
      errors++; $display("FAIL tmo_fire: err %b stall %b exp 1/0", bus.ctrl_error, bus.miss_stall);
    end
    bus.line_dirty = 4'b0011;
    sb.push_back('{flush: 4'b0001, fill: 4'b0000, region: exp_region});
    sb.push_back('{flush: 4'b0010, fill: 4'b0000, region: exp_region});
    pulse_flush_all();
    for (int p = 0; p < 2; p++) begin
      wait_pulse(20, fl, fi, rg, got);
      e = sb.pop_front();
      checks++;
      if (!got || {fl, fi, rg} !== e) begin
        errors++; $display("FAIL tmo_fa_%0d: got %b/%b/%h exp %b/%b/%h", p, fl, fi, rg, e.flush, e.fill, e.region);
      end
    end
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.flush_all_done) n_done++;
    end
    checks++;
    if (n_done != 1 || bus.ctrl_error !== 1'b1) begin
      errors++; $display("FAIL tmo_fa_done: done %0d err %b exp 1/1", n_done, bus.ctrl_error);
    end
    m_stuck = 1'b0;
    m_delay = 2;
    bus.line_dirty = 4'b0000;
    set_req(0, 0, 1, 0, 0, 32'h0000_0400);
    exp_region = 25'h8;
    exp_count = sat_inc(exp_count);
    sb.push_back('{flush: 4'b0000, fill: 4'b0010, region: exp_region});
    wait_pulse(10, fl, fi, rg, got);
    e = sb.pop_front();
    checks++;
    if (!got || {fl, fi, rg} !== e) begin
      errors++; $display("FAIL tmo_recover: got %b/%b/%h exp %b/%b/%h", fl, fi, rg, e.flush, e.fill, e.region);
    end
    set_req(0, 0, 0, 0, 0, 0);
    wait_stall_low(20, ok);
    checks++;
    if (!ok || bus.ctrl_error !== 1'b1) begin
      errors++; $display("FAIL tmo_sticky: stall %b err %b exp 0/1", bus.miss_stall, bus.ctrl_error);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] fl, fi; logic [24:0] rg; bit got; exp_t e;
    logic [51:0] outs;
    int p0, n_done, n_stall;
    m_delay = 20;
    bus.line_dirty = 4'b0010;
    set_req(0, 1, 0, 0, 32'h0000_1234, 0);
    sb.push_back('{flush: 4'b0010, fill: 4'b0010, region: 25'h24});
    wait_pulse(10, fl, fi, rg, got);
    e = sb.pop_front();
    checks++;
    if (!got || {fl, fi, rg} !== e) begin
      errors++; $display("FAIL mid_pulse: got %b/%b/%h exp %b/%b/%h", fl, fi, rg, e.flush, e.fill, e.region);
    end
    set_req(0, 0, 0, 0, 0, 0);
    tick(5);
    pulse_flush_all();
    tick(1);
    reset = 1'b1;
    #1;
    outs = {bus.line_flush, bus.line_fill, bus.cache_new_region, bus.miss_stall,
            bus.flush_all_done, bus.refill_count, bus.ctrl_error};
    checks++;
    if (outs !== 52'd0) begin errors++; $display("FAIL mid_reset_outputs: got %h exp 0", outs); end
    exp_count = '0;
    exp_region = '0;
    tick(2);
    reset = 1'b0;
    p0 = m_pulses;
    n_done = 0; n_stall = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.flush_all_done) n_done++;
      if (bus.miss_stall) n_stall++;
    end
    checks++;
    if (n_done != 0 || n_stall != 0 || m_pulses != p0) begin
      errors++; $display("FAIL mid_pending_cleared: done %0d stall %0d pulses %0d exp 0/0/0", n_done, n_stall, m_pulses - p0);
    end
    bus.line_dirty = 4'b0000;
  endtask

  task automatic test_saturation();
    logic [3:0] fl, fi; logic [24:0] rg; bit got, ok; exp_t e;
    m_delay = 1;
    for (int n = 0; n < int'(SAT) + 2; n++) begin
      set_req(1, 0, 0, 32'(n) << 7, 0, 0);
      exp_region = 25'(n);
      exp_count = sat_inc(exp_count);
      sb.push_back('{flush: 4'b0000, fill: 4'b0010, region: exp_region});
      wait_pulse(10, fl, fi, rg, got);
      e = sb.pop_front();
      checks++;
      if (!got || {fl, fi, rg} !== e || bus.refill_count !== exp_count) begin
        errors++; $display("FAIL sat_%0d: got %b/%b/%h cnt %0d exp %b/%b/%h cnt %0d", n, fl, fi, rg, bus.refill_count, e.flush, e.fill, e.region, exp_count);
      end
      set_req(0, 0, 0, 0, 0, 0);
      wait_stall_low(20, ok);
      if (!ok) begin checks++; errors++; $display("FAIL sat_release_%0d: stall %b exp 0", n, bus.miss_stall); end
    end
    checks++;
    if (bus.refill_count !== SAT || sb.size() != 0) begin
      errors++; $display("FAIL sat_final: cnt %0d queue %0d exp %0d/0", bus.refill_count, sb.size(), SAT);
    end
  endtask

  initial begin
    test_reset();
    test_refill_clean();
    test_refill_dirty();
    test_priority();
    test_no_action();
    test_flush_all();
    test_timeout();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end
endmodule
